// File: rtl/wb_scheduler.sv
// wb_scheduler: writeback-slot scheduler with shifting reservation table and cache-miss hold
// Ports:
//   clk_i, rsn_i        clock (rising edge), synchronous active-high reset
//   issue_valid_i       decode holds a valid instruction
//   issue_class_i       0 NONE, 1 ALU, 2 MEM, 3 MUL
//   issue_wr_en_i       instruction writes an integer register
//   issue_dest_i        destination register
//   mem_miss_i          cache stage reports a miss this cycle
//   mem_fill_i          pending miss data is available
//   kill_i              pipeline flush
//   stall_o             decode must hold (combinational)
//   wb_valid_o          a result is written back this cycle
//   wb_src_o            writeback latch source select, 1 ALU / 2 MEM / 3 MUL
//   wb_dest_o           destination register of the writeback
//   hold_o              memory-miss hold active
//   stall_cnt_o         saturating count of stall cycles
module wb_scheduler #(
    parameter int LAT_ALU = 2,
    parameter int LAT_MEM = 4,
    parameter int LAT_MUL = 7,
    parameter int DEPTH   = 8
) (
    input  logic        clk_i,
    input  logic        rsn_i,
    input  logic        issue_valid_i,
    input  logic [1:0]  issue_class_i,
    input  logic        issue_wr_en_i,
    input  logic [4:0]  issue_dest_i,
    input  logic        mem_miss_i,
    input  logic        mem_fill_i,
    input  logic        kill_i,
    output logic        stall_o,
    output logic        wb_valid_o,
    output logic [1:0]  wb_src_o,
    output logic [4:0]  wb_dest_o,
    output logic        hold_o,
    output logic [15:0] stall_cnt_o
);
    localparam int W = $clog2(DEPTH);
    localparam logic [W-1:0] LA = W'(LAT_ALU);
    localparam logic [W-1:0] LM = W'(LAT_MEM);
    localparam logic [W-1:0] LU = W'(LAT_MUL);

    typedef struct packed {
        logic       v;
        logic [1:0] src;
        logic [4:0] dest;
    } ent_t;

    ent_t res [DEPTH];
    ent_t pend;
    logic fill_q;
    logic [W-1:0] lat;
    logic [W-1:0] latm1;
    logic writing, accept, miss_take, pend_wb;

    always_comb begin
        lat       = issue_class_i == 2'd1 ? LA : issue_class_i == 2'd2 ? LM : LU;
        latm1     = lat - W'(1);
        writing   = issue_valid_i & (issue_class_i != 2'd0) & issue_wr_en_i;
        // pending is the hold state itself
        stall_o   = issue_valid_i & (pend.v | (writing & res[lat].v));
        accept    = writing & ~stall_o & ~kill_i;
        // a second miss while one is pending cannot be captured and is ignored
        miss_take = mem_miss_i & res[0].v & (res[0].src == 2'd2) & ~pend.v & ~kill_i;
        pend_wb   = pend.v & fill_q & ~res[0].v;
        wb_valid_o = (res[0].v & ~miss_take) | pend_wb;
        wb_src_o   = ~wb_valid_o ? 2'd0 : res[0].v ? res[0].src : 2'd2;
        wb_dest_o  = ~wb_valid_o ? 5'd0 : res[0].v ? res[0].dest : pend.dest;
        hold_o     = pend.v;
    end

    always_ff @(posedge clk_i) begin
        if (rsn_i | kill_i) begin
            for (int k = 0; k < DEPTH; k++) res[k] <= '0;
            pend   <= '0;
            fill_q <= 1'b0;
        end else begin
            for (int k = 0; k < DEPTH - 1; k++) res[k] <= res[k+1];
            res[DEPTH-1] <= '0;
            if (accept) res[latm1] <= {1'b1, issue_class_i, issue_dest_i};
            if (miss_take) pend <= res[0];
            if (pend_wb) begin
                pend.v <= 1'b0;
                fill_q <= 1'b0;
            end else if (pend.v & mem_fill_i) begin
                fill_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rsn_i) stall_cnt_o <= '0;
        else if (stall_o & ~&stall_cnt_o) stall_cnt_o <= stall_cnt_o + 16'd1;
    end
endmodule

// File: tb/tb_wb_scheduler.sv
// tb_wb_scheduler: directed self-checking bench for wb_scheduler
module tb_wb_scheduler;
    logic        clk = 1'b0;
    logic        rsn, iv, wr, miss, fill, kill;
    logic [1:0]  cls;
    logic [4:0]  dest;
    logic        stall, wbv, hold;
    logic [1:0]  wbs;
    logic [4:0]  wbd;
    logic [15:0] cnt;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    wb_scheduler dut (
        .clk_i(clk), .rsn_i(rsn), .issue_valid_i(iv), .issue_class_i(cls),
        .issue_wr_en_i(wr), .issue_dest_i(dest), .mem_miss_i(miss),
        .mem_fill_i(fill), .kill_i(kill), .stall_o(stall), .wb_valid_o(wbv),
        .wb_src_o(wbs), .wb_dest_o(wbd), .hold_o(hold), .stall_cnt_o(cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        iv = 0; cls = 0; wr = 0; dest = 0; miss = 0; fill = 0; kill = 0;
    endtask

    task automatic issue(input logic [1:0] c, input logic w, input logic [4:0] d);
        iv = 1; cls = c; wr = w; dest = d;
        #1;
    endtask

    task automatic do_reset();
        idle();
        rsn = 1;
        tick();
        rsn = 0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({wbv, wbs, wbd, hold, cnt, stall} !== 26'd0) begin
            bad++;
            $display("FAIL reset_state got v=%b s=%0d d=%0d h=%b c=%0d st=%b want all 0", wbv, wbs, wbd, hold, cnt, stall);
        end
    endtask

    task automatic test_alu();
        do_reset();
        issue(2'd1, 1, 5'd5);
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL alu_stall got=%b want=0", stall); end
        tick(); idle();
        total++;
        if (wbv !== 1'b0) begin bad++; $display("FAIL alu_early got=%b want=0", wbv); end
        tick();
        total++;
        if ({wbv, wbs, wbd} !== {1'b1, 2'd1, 5'd5}) begin
            bad++; $display("FAIL alu_wb got v=%b s=%0d d=%0d want v=1 s=1 d=5", wbv, wbs, wbd);
        end
        tick();
        total++;
        if (wbv !== 1'b0) begin bad++; $display("FAIL alu_after got=%b want=0", wbv); end
    endtask

    task automatic test_conflict();
        do_reset();
        issue(2'd3, 1, 5'd3);
        tick(); idle(); tick(); tick();
        issue(2'd2, 1, 5'd4);
        total++;
        if (stall !== 1'b1) begin bad++; $display("FAIL conflict_c3 got=%b want=1", stall); end
        tick();
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL conflict_c4 got=%b want=0", stall); end
        tick(); idle(); tick(); tick();
        total++;
        if ({wbv, wbs, wbd} !== {1'b1, 2'd3, 5'd3}) begin
            bad++; $display("FAIL conflict_mul got v=%b s=%0d d=%0d want v=1 s=3 d=3", wbv, wbs, wbd);
        end
        tick();
        total++;
        if ({wbv, wbs, wbd} !== {1'b1, 2'd2, 5'd4}) begin
            bad++; $display("FAIL conflict_mem got v=%b s=%0d d=%0d want v=1 s=2 d=4", wbv, wbs, wbd);
        end
        total++;
        if (cnt !== 16'd1) begin bad++; $display("FAIL conflict_cnt got=%0d want=1", cnt); end
    endtask

    task automatic test_store();
        do_reset();
        issue(2'd3, 1, 5'd3);
        tick(); idle(); tick(); tick();
        issue(2'd2, 0, 5'd4);
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL store_stall got=%b want=0", stall); end
        tick(); idle(); tick(); tick(); tick();
        total++;
        if ({wbv, wbs} !== {1'b1, 2'd3}) begin bad++; $display("FAIL store_mul got v=%b s=%0d want v=1 s=3", wbv, wbs); end
        tick();
        total++;
        if (wbv !== 1'b0) begin bad++; $display("FAIL store_noentry got=%b want=0", wbv); end
    endtask

    task automatic test_miss();
        do_reset();
        issue(2'd2, 1, 5'd9);
        tick(); idle(); tick(); tick(); tick();
        miss = 1; #1;
        total++;
        if (wbv !== 1'b0) begin bad++; $display("FAIL miss_suppress got=%b want=0", wbv); end
        total++;
        if (hold !== 1'b0) begin bad++; $display("FAIL miss_hold_c4 got=%b want=0", hold); end
        tick(); miss = 0;
        total++;
        if (hold !== 1'b1) begin bad++; $display("FAIL miss_hold_c5 got=%b want=1", hold); end
        tick();
        issue(2'd1, 1, 5'd1);
        total++;
        if (stall !== 1'b1) begin bad++; $display("FAIL miss_stall got=%b want=1", stall); end
        tick(); idle(); tick(); tick(); tick();
        fill = 1;
        tick(); fill = 0;
        total++;
        if ({wbv, wbs, wbd, hold} !== {1'b1, 2'd2, 5'd9, 1'b1}) begin
            bad++; $display("FAIL miss_pend got v=%b s=%0d d=%0d h=%b want v=1 s=2 d=9 h=1", wbv, wbs, wbd, hold);
        end
        tick();
        total++;
        if ({wbv, hold} !== 2'b00) begin bad++; $display("FAIL miss_release got v=%b h=%b want v=0 h=0", wbv, hold); end
        total++;
        if (cnt !== 16'd1) begin bad++; $display("FAIL miss_cnt got=%0d want=1", cnt); end
    endtask

    task automatic test_priority();
        do_reset();
        issue(2'd2, 1, 5'd12);
        tick(); idle(); tick(); tick(); tick();
        miss = 1;
        issue(2'd1, 1, 5'd6);
        tick(); idle();
        fill = 1;
        tick(); fill = 0;
        total++;
        if ({wbv, wbs, wbd} !== {1'b1, 2'd1, 5'd6}) begin
            bad++; $display("FAIL prio_alu got v=%b s=%0d d=%0d want v=1 s=1 d=6", wbv, wbs, wbd);
        end
        tick();
        total++;
        if ({wbv, wbs, wbd} !== {1'b1, 2'd2, 5'd12}) begin
            bad++; $display("FAIL prio_pend got v=%b s=%0d d=%0d want v=1 s=2 d=12", wbv, wbs, wbd);
        end
    endtask

    task automatic test_kill();
        do_reset();
        issue(2'd1, 1, 5'd7);
        tick(); idle();
        kill = 1;
        tick(); kill = 0;
        issue(2'd1, 1, 5'd8);
        total++;
        if ({wbv, stall} !== 2'b00) begin bad++; $display("FAIL kill_wb got v=%b st=%b want v=0 st=0", wbv, stall); end
        tick(); idle(); tick();
        total++;
        if ({wbv, wbd} !== {1'b1, 5'd8}) begin bad++; $display("FAIL kill_reissue got v=%b d=%0d want v=1 d=8", wbv, wbd); end
    endtask

    task automatic test_kill_miss();
        do_reset();
        issue(2'd2, 1, 5'd10);
        tick(); idle(); tick(); tick(); tick();
        miss = 1; kill = 1; #1;
        total++;
        if ({wbv, wbs, wbd} !== {1'b1, 2'd2, 5'd10}) begin
            bad++; $display("FAIL killmiss_wb got v=%b s=%0d d=%0d want v=1 s=2 d=10", wbv, wbs, wbd);
        end
        tick(); idle();
        total++;
        if (hold !== 1'b0) begin bad++; $display("FAIL killmiss_hold got=%b want=0", hold); end
    endtask

    task automatic test_saturate();
        do_reset();
        issue(2'd2, 1, 5'd2);
        tick(); idle(); tick(); tick(); tick();
        miss = 1;
        tick(); miss = 0;
        issue(2'd0, 0, 5'd0);
        for (int i = 0; i < 100; i++) tick();
        total++;
        if (cnt !== 16'd100) begin bad++; $display("FAIL sat_mid got=%0d want=100", cnt); end
        for (int i = 0; i < 69900; i++) tick();
        total++;
        if (cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_top got=%0h want=ffff", cnt); end
        do_reset();
        total++;
        if ({cnt, hold} !== 17'd0) begin bad++; $display("FAIL sat_reset got c=%0d h=%b want c=0 h=0", cnt, hold); end
    endtask

    initial begin
        rsn = 1;
        idle();
        test_reset();
        test_alu();
        test_conflict();
        test_store();
        test_miss();
        test_priority();
        test_kill();
        test_kill_miss();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
